// File: rtl/seq_ctrl_pkg.sv
// Shared types and helpers for the serial sequence detector.
// Holds the controller state encoding and the pattern mask helper.
package seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        SHIFT,
        DONE
    } ctrl_state_t;

    localparam int DATA_W_DEF  = 8;
    localparam int PAT_MAX_DEF = 8;
    localparam int CNT_W_DEF   = 16;
    localparam int MASK_MAX    = 64;

    // Low len bits set; callers truncate to their pattern width.
    function automatic logic [MASK_MAX-1:0] len_mask(input int len);
        logic [MASK_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_MAX; i++) begin
            m[i] = (i < len);
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// Bit-serial pattern matcher: history shift register and masked compare.
// History only counts as valid once enough bits arrived since the last clear.
module seq_match_core
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_MAX = PAT_MAX_DEF,
    localparam int LEN_W  = $clog2(PAT_MAX) + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               shift_en,
    input  logic               shift_bit,
    input  logic               clr,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               hit
);

    logic [PAT_MAX-1:0] history;
    logic [PAT_MAX-1:0] new_hist;
    logic [PAT_MAX-1:0] mask;
    logic [LEN_W-1:0]   hist_cnt;
    logic [LEN_W:0]     cnt_next;

    assign new_hist = {history[PAT_MAX-2:0], shift_bit};
    assign mask     = PAT_MAX'(len_mask(int'(cfg_len)));
    assign cnt_next = {1'b0, hist_cnt} + (LEN_W+1)'(1);

    assign hit = shift_en
               && (cnt_next >= {1'b0, cfg_len})
               && (((new_hist ^ cfg_pattern) & mask) == '0);

    // Shift history and track how many valid bits it holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            history  <= '0;
            hist_cnt <= '0;
        end else if (clr) begin
            history  <= '0;
            hist_cnt <= '0;
        end else if (shift_en) begin
            if (hit && !cfg_overlap) begin
                history  <= '0;
                hist_cnt <= '0;
            end else begin
                history <= new_hist;
                if (hist_cnt < cfg_len) begin
                    hist_cnt <= cnt_next[LEN_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Word-to-bit scheduler around the pattern matcher.
// Owns the run FSM, word register, bit index and match counter.
module seq_detect_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PAT_MAX = PAT_MAX_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    localparam int LEN_W  = $clog2(PAT_MAX) + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    output logic               cfg_err,
    input  logic               start,
    input  logic               abort,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               bit_valid,
    output logic               bit_out,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    ctrl_state_t        state;
    logic               cfg_loaded;
    logic [PAT_MAX-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   tgt_q;
    logic [DATA_W-1:0]  word;
    logic [IDX_W-1:0]   idx;

    logic               cfg_hs;
    logic               len_ok;
    logic               go;
    logic               shift_en;
    logic               cur_bit;
    logic               hit;
    logic [CNT_W-1:0]   cnt_inc;
    logic               tgt_hit;

    assign cfg_ready = (state == IDLE) || (state == DONE);
    assign in_ready  = (state == ARMED);
    assign busy      = (state == ARMED) || (state == SHIFT);
    assign done      = (state == DONE);

    assign cfg_hs   = cfg_valid && cfg_ready;
    assign len_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_MAX));
    assign go       = !abort && cfg_ready && start && cfg_loaded && !cfg_hs;
    assign shift_en = !abort && (state == SHIFT);
    assign cur_bit  = word[idx];
    assign cnt_inc  = (&match_count) ? match_count : match_count + CNT_W'(1);
    assign tgt_hit  = hit && (tgt_q != '0) && (cnt_inc == tgt_q);

    seq_match_core #(
        .PAT_MAX (PAT_MAX)
    ) u_core (
        .clk         (clk),
        .reset_n     (reset_n),
        .shift_en    (shift_en),
        .shift_bit   (cur_bit),
        .clr         (go),
        .cfg_pattern (pat_q),
        .cfg_len     (len_q),
        .cfg_overlap (ovl_q),
        .hit         (hit)
    );

    // Run FSM with config latch, word serializer and match counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cfg_loaded  <= 1'b0;
            pat_q       <= '0;
            len_q       <= '0;
            ovl_q       <= 1'b0;
            tgt_q       <= '0;
            word        <= '0;
            idx         <= '0;
            match_count <= '0;
            bit_valid   <= 1'b0;
            bit_out     <= 1'b0;
            match       <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            match     <= 1'b0;
            cfg_err   <= 1'b0;
            if (abort) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE, DONE: begin
                        if (cfg_hs) begin
                            if (len_ok) begin
                                pat_q      <= cfg_pattern;
                                len_q      <= cfg_len;
                                ovl_q      <= cfg_overlap;
                                tgt_q      <= cfg_target;
                                cfg_loaded <= 1'b1;
                            end else begin
                                cfg_err <= 1'b1;
                            end
                        end else if (go) begin
                            state       <= ARMED;
                            match_count <= '0;
                        end
                    end
                    ARMED: begin
                        if (in_valid) begin
                            word  <= in_data;
                            idx   <= IDX_W'(DATA_W - 1);
                            state <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        bit_valid <= 1'b1;
                        bit_out   <= cur_bit;
                        match     <= hit;
                        if (hit) begin
                            match_count <= cnt_inc;
                        end
                        if (tgt_hit) begin
                            state <= DONE;
                        end else if (idx == '0) begin
                            state <= ARMED;
                        end else begin
                            idx <= idx - IDX_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Randomized and directed bench for seq_detect_ctrl.
// Expected bits and matches come from a bit-queue model of the stream.
module tb_seq_detect_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [7:0]  cfg_pattern = '0;
    logic [3:0]  cfg_len = '0;
    logic        cfg_overlap = 1'b0;
    logic [15:0] cfg_target = '0;
    logic        cfg_err;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        bit_valid;
    logic        bit_out;
    logic        match;
    logic [15:0] match_count;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_pat;
    int          m_len;
    bit          m_ovl;
    int          m_tgt;
    int          m_cnt;
    bit          m_loaded;
    bit          m_done;
    bit          hq[$];

    seq_detect_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .cfg_err     (cfg_err),
        .start       (start),
        .abort       (abort),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .bit_valid   (bit_valid),
        .bit_out     (bit_out),
        .match       (match),
        .match_count (match_count),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream model: a match is the last m_len bits since the last clear.
    task automatic model_shift(input bit b, output bit h);
        hq.push_back(b);
        h = 1'b0;
        if (hq.size() >= m_len) begin
            h = 1'b1;
            for (int i = 0; i < m_len; i++) begin
                if (hq[hq.size() - 1 - i] != m_pat[i]) h = 1'b0;
            end
        end
        if (hq.size() > 16) void'(hq.pop_front());
        if (h) begin
            if (m_cnt < 65535) m_cnt++;
            if (!m_ovl) hq.delete();
            if (m_tgt != 0 && m_cnt == m_tgt) m_done = 1'b1;
        end
    endtask

    task automatic apply_reset(input string nm);
        reset_n = 1'b0;
        #2;
        checks++;
        if ({bit_valid, bit_out, match, cfg_err, busy, done, in_ready} !== 7'b0
            || match_count !== 16'd0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s reset outs bv=%b bo=%b m=%b err=%b busy=%b done=%b ir=%b cnt=%0d cr=%b want all 0, cr=1",
                     nm, bit_valid, bit_out, match, cfg_err, busy, done,
                     in_ready, match_count, cfg_ready);
        end
        m_loaded = 1'b0;
        m_done = 1'b0;
        m_cnt = 0;
        hq.delete();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic go_idle(input string nm);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        m_done = 1'b0;
        checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s go_idle cfg_ready=%b busy=%b want 1 0",
                     nm, cfg_ready, busy);
        end
    endtask

    task automatic do_cfg(input string nm, input logic [7:0] pat,
                          input logic [3:0] len, input bit ovl,
                          input logic [15:0] tgt);
        bit legal;
        legal = (len >= 4'd1) && (len <= 4'd8);
        cfg_valid = 1'b1;
        cfg_pattern = pat;
        cfg_len = len;
        cfg_overlap = ovl;
        cfg_target = tgt;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s cfg_ready=%b want 1", nm, cfg_ready);
        end
        tick();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_err !== !legal) begin
            errors++;
            $display("FAIL %s cfg_err=%b want %b", nm, cfg_err, !legal);
        end
        tick();
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL %s cfg_err held=%b want 0", nm, cfg_err);
        end
        if (legal) begin
            m_pat = pat;
            m_len = int'(len);
            m_ovl = ovl;
            m_tgt = int'(tgt);
            m_loaded = 1'b1;
        end
    endtask

    task automatic do_start(input string nm);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (m_loaded) begin
            m_cnt = 0;
            m_done = 1'b0;
            hq.delete();
        end
        checks++;
        if (busy !== m_loaded || in_ready !== m_loaded
            || match_count !== 16'(m_cnt)) begin
            errors++;
            $display("FAIL %s start busy=%b ir=%b cnt=%0d want %b %b %0d",
                     nm, busy, in_ready, match_count, m_loaded, m_loaded, m_cnt);
        end
    endtask

    task automatic send_word(input string nm, input logic [7:0] w);
        bit h;
        in_valid = 1'b1;
        in_data = w;
        if (m_done) begin
            repeat (4) begin
                checks++;
                if (in_ready !== 1'b0 || bit_valid !== 1'b0 || done !== 1'b1) begin
                    errors++;
                    $display("FAIL %s refuse ir=%b bv=%b done=%b want 0 0 1",
                             nm, in_ready, bit_valid, done);
                end
                tick();
            end
            in_valid = 1'b0;
            return;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept in_ready=%b want 1", nm, in_ready);
        end
        tick();
        in_valid = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            tick();
            model_shift(w[k], h);
            checks++;
            if (bit_valid !== 1'b1 || bit_out !== w[k] || match !== h
                || match_count !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL %s bit%0d bv=%b bo=%b m=%b cnt=%0d want 1 %b %b %0d",
                         nm, k, bit_valid, bit_out, match, match_count,
                         w[k], h, m_cnt);
            end
            if (m_done) begin
                checks++;
                if (done !== 1'b1 || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s stop done=%b ir=%b want 1 0",
                             nm, done, in_ready);
                end
                for (int j = 0; j <= k; j++) begin
                    tick();
                    checks++;
                    if (bit_valid !== 1'b0 || match_count !== 16'(m_cnt)) begin
                        errors++;
                        $display("FAIL %s after stop bv=%b cnt=%0d want 0 %0d",
                                 nm, bit_valid, match_count, m_cnt);
                    end
                end
                return;
            end
        end
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s rearm ir=%b busy=%b want 1 1", nm, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        apply_reset("reset");
    endtask

    task automatic test_overlap();
        go_idle("ovl");
        do_cfg("ovl", 8'h0D, 4'd4, 1'b1, 16'd0);
        do_start("ovl");
        send_word("ovl_w0", 8'hED);
        send_word("ovl_w1", 8'h6A);
        checks++;
        if (match_count !== 16'd3) begin
            errors++;
            $display("FAIL ovl count=%0d want 3", match_count);
        end
    endtask

    task automatic test_nonoverlap();
        go_idle("novl");
        do_cfg("novl", 8'h0D, 4'd4, 1'b0, 16'd0);
        do_start("novl");
        send_word("novl_w0", 8'hED);
        checks++;
        if (match_count !== 16'd1) begin
            errors++;
            $display("FAIL novl count=%0d want 1", match_count);
        end
    endtask

    task automatic test_target_boundary();
        go_idle("tgt2");
        do_cfg("tgt2", 8'h0D, 4'd4, 1'b1, 16'd2);
        do_start("tgt2");
        send_word("tgt2_w0", 8'hED);
        checks++;
        if (done !== 1'b1 || match_count !== 16'd2) begin
            errors++;
            $display("FAIL tgt2 done=%b cnt=%0d want 1 2", done, match_count);
        end
        send_word("tgt2_w1", 8'h6A);
    endtask

    task automatic test_midword();
        do_cfg("tgt1", 8'h0D, 4'd4, 1'b1, 16'd1);
        do_start("tgt1");
        send_word("tgt1_w0", 8'hED);
        checks++;
        if (done !== 1'b1 || match_count !== 16'd1) begin
            errors++;
            $display("FAIL tgt1 done=%b cnt=%0d want 1 1", done, match_count);
        end
    endtask

    task automatic test_illegal();
        apply_reset("ill_rst");
        do_cfg("ill_len0", 8'h0D, 4'd0, 1'b1, 16'd0);
        do_start("ill_start");
        do_cfg("ill_ok", 8'h0D, 4'd4, 1'b1, 16'd0);
        do_cfg("ill_len9", 8'hFF, 4'd9, 1'b0, 16'd1);
        do_start("ill_keep");
        send_word("ill_w0", 8'hED);
        checks++;
        if (match_count !== 16'd2) begin
            errors++;
            $display("FAIL ill_keep count=%0d want 2", match_count);
        end
    endtask

    task automatic test_abort();
        bit h;
        go_idle("abt");
        do_cfg("abt", 8'h03, 4'd2, 1'b1, 16'd0);
        do_start("abt");
        in_valid = 1'b1;
        in_data = 8'hED;
        tick();
        in_valid = 1'b0;
        for (int k = 7; k >= 6; k--) begin
            tick();
            model_shift(in_data[k], h);
            checks++;
            if (bit_valid !== 1'b1 || match !== h) begin
                errors++;
                $display("FAIL abt bit%0d bv=%b m=%b want 1 %b",
                         k, bit_valid, match, h);
            end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1 || bit_valid !== 1'b0
            || match_count !== 16'd1) begin
            errors++;
            $display("FAIL abt idle busy=%b cr=%b bv=%b cnt=%0d want 0 1 0 1",
                     busy, cfg_ready, bit_valid, match_count);
        end
        tick();
        checks++;
        if (bit_valid !== 1'b0) begin
            errors++;
            $display("FAIL abt quiet bv=%b want 0", bit_valid);
        end
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || match_count !== 16'd1) begin
            errors++;
            $display("FAIL abt_vs_start busy=%b cnt=%0d want 0 1",
                     busy, match_count);
        end
        do_start("abt_restart");
        send_word("abt_w0", 8'hED);
    endtask

    task automatic test_reset_mid();
        bit h;
        go_idle("rmid");
        do_cfg("rmid", 8'h0D, 4'd4, 1'b1, 16'd0);
        do_start("rmid");
        in_valid = 1'b1;
        in_data = 8'hB5;
        tick();
        in_valid = 1'b0;
        for (int k = 7; k >= 5; k--) begin
            tick();
            model_shift(in_data[k], h);
        end
        apply_reset("rmid_rst");
        do_start("rmid_ign");
        do_cfg("rmid_cfg", 8'h0D, 4'd4, 1'b1, 16'd0);
        do_start("rmid_go");
        send_word("rmid_w0", 8'hED);
    endtask

    task automatic test_random();
        for (int r = 0; r < 10; r++) begin
            logic [7:0] pat;
            logic [3:0] len;
            bit ovl;
            logic [15:0] tgt;
            pat = 8'($urandom);
            len = 4'($urandom_range(1, 8));
            ovl = 1'($urandom);
            tgt = 16'($urandom_range(0, 3));
            go_idle("rnd");
            do_cfg("rnd", pat, len, ovl, tgt);
            do_start("rnd");
            for (int w = 0; w < 5; w++) begin
                send_word("rnd_w", 8'($urandom));
                repeat ($urandom_range(0, 2)) tick();
            end
            checks++;
            if (match_count !== 16'(m_cnt) || done !== m_done) begin
                errors++;
                $display("FAIL rnd%0d end cnt=%0d done=%b want %0d %b",
                         r, match_count, done, m_cnt, m_done);
            end
        end
    endtask

    initial begin
        m_pat = '0;
        m_len = 1;
        m_ovl = 1'b0;
        m_tgt = 0;
        m_cnt = 0;
        m_loaded = 1'b0;
        m_done = 1'b0;
        tick();
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_target_boundary();
        test_midword();
        test_illegal();
        test_abort();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Controller that schedules serial pattern detection over a parallel word stream.
- Accepts a runtime pattern configuration and DATA_W-bit words through valid/ready handshakes.
- Serializes each word MSB-first into a programmable sequence matcher and counts matches, in overlapping or non-overlapping mode.
- Stops and raises done when a programmed match target is reached. Sits between a word-oriented producer and the detection/interrupt logic.

Parameters:
- DATA_W, 8, width of each input word.
- PAT_MAX, 8, maximum pattern length in bits (must be ≥2).
- CNT_W, 16, width of the match counter and target.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  configuration offer.
- cfg_ready  out  1  high in IDLE and DONE only (combinational from state).
- cfg_pattern  in  PAT_MAX  pattern; bit [len-1] is the oldest bit, bit [0] the newest.
- cfg_len  in  $clog2(PAT_MAX)+1  pattern length; legal range 1..PAT_MAX.
- cfg_overlap  in  1  1 = overlapping matches count, 0 = history cleared after each match.
- cfg_target  in  CNT_W  match count that ends a run; 0 = unlimited.
- cfg_err  out  1  1-cycle pulse when an illegal cfg_len is offered and accepted.
- start  in  1  level sampled; begins a run.
- abort  in  1  level sampled; cancels the run.
- in_valid  in  1  word offer.
- in_ready  out  1  high only in ARMED.
- in_data  in  DATA_W  word to serialize.
- bit_valid  out  1  registered; a bit was shifted last cycle.
- bit_out  out  1  registered; the bit shifted last cycle.
- match  out  1  registered 1-cycle pulse, aligned with the bit_valid of the completing bit.
- match_count  out  CNT_W  matches in the current run; saturates at all-ones.
- busy  out  1  high in ARMED or SHIFT.
- done  out  1  held high in DONE.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State = IDLE; cfg_loaded=0.
  - History and hist_cnt cleared.
  - All outputs 0 except cfg_ready=1.
- States: IDLE, ARMED, SHIFT, DONE. Transitions are evaluated per cycle in priority order: abort, then everything else.
- Abort from any state:
  - Go to IDLE.
  - Any partial word is discarded with no further bit_valid.
  - match_count and the configuration are kept.
  - abort wins over a simultaneous start.
- Configuration (IDLE or DONE, cfg_valid & cfg_ready):
  - Legal cfg_len: latch all cfg_* fields and set cfg_loaded=1.
  - cfg_len=0 or cfg_len>PAT_MAX: keep the old config and pulse cfg_err the next cycle.
- Start:
  - Condition: IDLE or DONE, with start & cfg_loaded & no config handshake in the same cycle.
  - Action: go to ARMED; clear match_count, history and hist_cnt.
  - start without cfg_loaded is ignored.
- ARMED: in_ready=1. On in_valid, latch in_data, set bit index = DATA_W-1 and go to SHIFT.
- SHIFT, each cycle:
  - b = word[idx]; history <= {history[PAT_MAX-2:0], b}; hist_cnt saturates at cfg_len.
  - hit when (hist_cnt+1 ≥ cfg_len) and the low cfg_len bits of the new history equal the low cfg_len bits of cfg_pattern.
  - On hit:
    - Pulse match; increment match_count with saturation.
    - If cfg_overlap=0, clear hist_cnt to 0.
- Leaving SHIFT:
  - Target reached (cfg_target≠0 and the new count == cfg_target): go to DONE immediately. Remaining bits of the word are dropped; history is frozen.
  - Otherwise, after idx==0: return to ARMED.
  - One word therefore costs DATA_W+1 cycles.
- History persistence: history persists across word boundaries, so a pattern may straddle words. It is cleared only on reset, start and non-overlap match.
- DONE: done=1, in_ready=0, further words are refused, match_count is held.

Decomposition:
- Package seq_ctrl_pkg:
  - ctrl_state_t enum (IDLE, ARMED, SHIFT, DONE).
  - Default constants for DATA_W, PAT_MAX and CNT_W.
  - Helper function for the length-mask generation.
- Sub-module seq_match_core:
  - Contents: history shift register, hist_cnt, masked compare, overlap clear.
  - Interface: inputs shift_en, bit, clr, cfg_pattern, cfg_len, cfg_overlap; output hit.
- The controller FSM, word register, bit index and counter stay in seq_detect_ctrl.

Test Plan:
- Overlap test: cfg pattern=4'b1101, len=4, overlap=1, target=0; start; words 0xED then 0x6A (stream 11101101 01101010) -> matches with bits 5, 8 and 13 (1-based); match_count=3; in_ready returns high 9 cycles after each accept.
- Non-overlap test: same config with overlap=0, word 0xED -> exactly one match on bit 5; match_count=1.
- Target on word boundary: target=2, overlap=1, word 0xED -> match on bits 5 and 8; done rises after bit 8; a second word offered with in_valid=1 is never accepted (in_ready=0).
- Mid-word stop: target=1, word 0xED -> match on bit 5, then DONE; no bit_valid for bits 6-8; match_count=1.
- Illegal configuration: cfg_len=0 from reset -> cfg_err one-cycle pulse; cfg_loaded stays 0; a subsequent start leaves the state in IDLE (busy=0).
- Abort and reset: abort asserted at the 3rd SHIFT cycle -> IDLE next cycle with no further bit_valid and match_count kept. In a separate run, reset_n low mid-SHIFT -> all outputs 0 immediately, cfg_ready=1, and start is ignored until a new config is accepted.
